// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART_TX serializer between NUM_REQ byte sources
module uart_tx_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_BITS     = 8,
  parameter int MAX_BURST     = 4,
  parameter int START_TIMEOUT = 4,
  localparam int IDW          = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1
) (
  input  logic                           PCLK,
  input  logic                           PRESETn,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           tx_start,
  output logic [DATA_BITS-1:0]           tx_data,
  input  logic                           tx_busy,
  output logic [IDW-1:0]                 grant_id,
  output logic                           grant_active,
  output logic                           start_err
);
  localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
  localparam int WW = $clog2(START_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} state_t;
  state_t               r_state;
  logic [IDW-1:0]       r_ptr;
  logic [BW-1:0]        r_burst;
  logic [WW-1:0]        r_wd;
  logic [IDW-1:0]       w_nxt, w_base, w_win, w_id;
  logic                 w_keep, w_load;
  logic [DATA_BITS-1:0] w_data;
  function automatic logic [IDW-1:0] rr_pick(input logic [IDW-1:0] base, input logic [NUM_REQ-1:0] valid);
    logic [IDW-1:0] win;
    win = base;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (valid[(int'(base) + k) % NUM_REQ]) win = IDW'((int'(base) + k) % NUM_REQ);
    return win;
  endfunction
  // at a frame end the scan starts one past the current grant, as if the pointer had already advanced
  always_comb begin
    w_nxt  = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    w_keep = req_valid[grant_id] && (int'(r_burst) < MAX_BURST - 1);
    w_base = (r_state == WAIT_DONE) ? w_nxt : r_ptr;
    w_win  = rr_pick(w_base, req_valid);
    w_id   = (r_state == WAIT_DONE && w_keep) ? grant_id : w_win;
    w_data = req_data[int'(w_id) * DATA_BITS +: DATA_BITS];
    w_load = |req_valid && (r_state == IDLE || (r_state == WAIT_DONE && !tx_busy));
  end
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_burst      <= '0;
      r_wd         <= '0;
      req_ready    <= '0;
      tx_start     <= 1'b0;
      tx_data      <= '0;
      grant_id     <= '0;
      grant_active <= 1'b0;
      start_err    <= 1'b0;
    end else begin
      tx_start  <= w_load;
      req_ready <= w_load ? NUM_REQ'(1) << w_id : '0;
      start_err <= 1'b0;
      if (w_load) begin
        r_state      <= LOAD;
        grant_id     <= w_id;
        tx_data      <= w_data;
        grant_active <= 1'b1;
        r_burst      <= (r_state == WAIT_DONE && w_keep) ? r_burst + 1'b1 : '0;
        if (r_state == WAIT_DONE && !w_keep) r_ptr <= w_nxt;
      end else begin
        case (r_state)
          LOAD: begin
            r_wd    <= '0;
            r_state <= WAIT_BUSY;
          end
          WAIT_BUSY:
            if (tx_busy) r_state <= WAIT_DONE;
            else if (r_wd == WW'(START_TIMEOUT - 1)) begin
              start_err    <= 1'b1;
              grant_active <= 1'b0;
              r_ptr        <= w_nxt;
              r_state      <= IDLE;
            end else r_wd <= r_wd + 1'b1;
          WAIT_DONE:
            if (!tx_busy) begin
              grant_active <= 1'b0;
              r_ptr        <= w_nxt;
              r_state      <= IDLE;
            end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: UART_TX model plus transaction-level schedule predictor for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NR = 4, DB = 8, MB = 4, FRAME = 20;
  logic PCLK = 1'b0, PRESETn = 1'b0;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*DB-1:0] req_data;
  logic tx_start, tx_busy, grant_active, start_err;
  logic [DB-1:0] tx_data;
  logic [1:0] grant_id;
  logic no_busy = 1'b0;
  int frame_cnt, stab_err = 0;
  logic [DB-1:0] cap;
  int checks = 0, passed = 0, m_ptr = 0;
  logic [DB-1:0] q[NR][$];
  int exp_id[$];
  logic [DB-1:0] exp_byte[$];

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_BITS(DB), .MAX_BURST(MB), .START_TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
    .grant_id(grant_id), .grant_active(grant_active), .start_err(start_err));

  always #5 PCLK = ~PCLK;

  // UART_TX stand-in: busy the cycle after tx_start, for FRAME cycles, byte must stay stable
  always @(posedge PCLK) begin
    if (!PRESETn) begin
      tx_busy   <= 1'b0;
      frame_cnt <= 0;
    end else if (tx_start && !no_busy) begin
      tx_busy   <= 1'b1;
      frame_cnt <= FRAME - 1;
      cap       <= tx_data;
    end else if (tx_busy) begin
      if (tx_data !== cap) stab_err <= stab_err + 1;
      if (frame_cnt == 0) tx_busy <= 1'b0;
      else frame_cnt <= frame_cnt - 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      req_valid[i] = q[i].size() > 0;
      req_data[i*DB +: DB] = (q[i].size() > 0) ? q[i][0] : 8'h00;
    end
  endtask

  // one clock; the byte a requester had accepted is dropped after the accepting edge
  task automatic tick();
    logic [NR-1:0] a;
    @(negedge PCLK);
    a = req_ready;
    @(posedge PCLK);
    #1;
    for (int i = 0; i < NR; i++) if (a[i] && q[i].size() > 0) void'(q[i].pop_front());
    drive();
  endtask

  // schedule every queued byte, all requesters holding valid from the start, by the round-robin/burst rules
  task automatic build_expect();
    int left[NR], k[NR];
    int cur = -1, b = 0, tot = 0;
    for (int i = 0; i < NR; i++) begin
      left[i] = q[i].size();
      k[i] = 0;
      tot += left[i];
    end
    while (tot > 0) begin
      if (cur >= 0 && left[cur] > 0 && b < MB - 1) b++;
      else begin
        int nxt;
        nxt = -1;
        if (cur >= 0) m_ptr = (cur + 1) % NR;
        for (int s = 0; s < NR; s++)
          if (nxt < 0 && left[(m_ptr + s) % NR] > 0) nxt = (m_ptr + s) % NR;
        cur = nxt;
        b = 0;
      end
      exp_id.push_back(cur);
      exp_byte.push_back(q[cur][k[cur]]);
      k[cur]++;
      left[cur]--;
      tot--;
    end
    if (cur >= 0) m_ptr = (cur + 1) % NR;
  endtask

  // called at posedge+1 with the DUT idle; runs until every predicted byte has started
  task automatic run_batch();
    int idx = 0, first = -1, bub = 0, ovl = 0, rdy = 0, budget;
    logic prev_busy, fell;
    logic [NR-1:0] a, er;
    build_expect();
    drive();
    budget = 30 * exp_id.size() + 10;
    prev_busy = tx_busy;
    fell = 1'b0;
    while (exp_id.size() > 0 && idx < budget) begin
      @(negedge PCLK);
      er = tx_start ? (NR'(1) << grant_id) : '0;
      if (req_ready !== er) rdy++;
      if (tx_start && tx_busy) ovl++;
      if (fell && !tx_start) bub++;
      fell = prev_busy && !tx_busy && exp_id.size() > 0;
      prev_busy = tx_busy;
      if (tx_start) begin
        if (first < 0) first = idx;
        chk("grant_id", grant_id, exp_id[0]);
        chk("tx_data", tx_data, exp_byte[0]);
        chk("grant_active", grant_active, 1);
        void'(exp_id.pop_front());
        void'(exp_byte.pop_front());
      end
      a = req_ready;
      idx++;
      @(posedge PCLK);
      #1;
      for (int i = 0; i < NR; i++) if (a[i] && q[i].size() > 0) void'(q[i].pop_front());
      drive();
    end
    chk("all_started", exp_id.size(), 0);
    chk("start_latency", first, 1);
    chk("zero_bubble", bub, 0);
    chk("start_while_busy", ovl, 0);
    chk("ready_onehot", rdy, 0);
    for (int n = 0; n < 60 && grant_active; n++) tick();
    chk("returns_idle", grant_active, 0);
    chk("data_stable", stab_err, 0);
  endtask

  initial begin
    int ls, le, nerr, eg, tot;
    logic ga;
    req_valid = '0;
    req_data = '0;
    repeat (3) @(posedge PCLK);
    #1;
    chk("reset_outputs", {tx_start, req_ready, tx_data, grant_id, grant_active, start_err}, 0);
    PRESETn = 1'b1;
    // burst: req0 streams six bytes while req1 waits with one
    for (int i = 1; i <= 6; i++) q[0].push_back(DB'(i));
    q[1].push_back(8'hEE);
    run_batch();
    // single request
    q[2].push_back(8'hA5);
    run_batch();
    // pointer now at 3: req3 then req0 across the wrap
    q[0].push_back(8'h30);
    q[3].push_back(8'h33);
    run_batch();
    // start timeout: busy never rises
    no_busy = 1'b1;
    q[0].push_back(8'h77);
    build_expect();
    eg = exp_id[0];
    exp_id.delete();
    exp_byte.delete();
    drive();
    ls = -1; le = -1; nerr = 0; ga = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (tx_start && ls < 0) begin
        ls = k;
        chk("timeout_grant", grant_id, eg);
      end
      if (start_err) begin
        nerr++;
        if (le < 0) begin
          le = k;
          ga = grant_active;
        end
      end
    end
    chk("timeout_delay", le - ls, 5);
    chk("timeout_pulses", nerr, 1);
    chk("timeout_active", ga, 0);
    no_busy = 1'b0;
    // fairness after timeout: scan starts at the next index
    for (int i = 0; i < NR; i++) q[i].push_back(DB'(8'h10 + i));
    run_batch();
    // reset during WAIT_DONE with req1/req3 pending
    q[2].push_back(8'h5A);
    drive();
    for (int k = 0; k < 30 && !(tx_busy && grant_active); k++) tick();
    repeat (3) tick();
    q[1].push_back(8'hC1);
    q[3].push_back(8'hC3);
    drive();
    repeat (2) tick();
    chk("pre_reset_frame", {grant_active, tx_busy, tx_start}, 3'b110);
    PRESETn = 1'b0;
    tick();
    chk("midframe_reset", {tx_start, req_ready, tx_data, grant_id, grant_active, start_err}, 0);
    PRESETn = 1'b1;
    m_ptr = 0;
    run_batch();
    // randomized batches
    for (int r = 0; r < 6; r++) begin
      tot = 0;
      for (int i = 0; i < NR; i++) begin
        int n;
        n = $urandom_range(0, 6);
        tot += n;
        for (int j = 0; j < n; j++) q[i].push_back(DB'($urandom));
      end
      if (tot == 0) q[$urandom_range(0, NR - 1)].push_back(DB'($urandom));
      run_batch();
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
